// File: rtl/sync_fifo_flags_if.sv
// Handshake and status bundle for sync_fifo_flags. The producer/consumer side uses the
// master modport and the FIFO uses the slave modport.
interface sync_fifo_flags_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic             winc;
    logic [WIDTH-1:0] wdata;
    logic             rinc;
    logic [WIDTH-1:0] rdata;
    logic             rvalid;
    logic             wfull;
    logic             rempty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output winc, wdata, rinc,
        input  rdata, rvalid, wfull, rempty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  winc, wdata, rinc,
        output rdata, rvalid, wfull, rempty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock register-array FIFO with occupancy count, almost thresholds, error pulses
// and selectable standard (registered) or first-word-fall-through read.
module sync_fifo_flags #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = 12,
    parameter int unsigned AE_LEVEL = 3,
    parameter int unsigned FWFT     = 0
) (
    input  logic               clk,
    input  logic               rstn,
    sync_fifo_flags_if.slave   bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;
    logic             wfull_q, wfull_d;
    logic             rempty_q, rempty_d;
    logic             afull_q, afull_d;
    logic             aempty_q, aempty_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             wr_acc_c, rd_acc_c;

    // Next-state: accept decisions use pre-edge flags; flags derive from next count
    always_comb begin
        wr_acc_c = bus.winc & ~wfull_q;
        rd_acc_c = bus.rinc & ~rempty_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        count_d  = count_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;

        if (wr_acc_c) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (rd_acc_c) begin
            rptr_d   = rptr_q + AW'(1);
            rdata_d  = mem_q[rptr_q];
            rvalid_d = 1'b1;
        end

        case ({wr_acc_c, rd_acc_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        wfull_d  = (count_d == CW'(DEPTH));
        rempty_d = (count_d == CW'(0));
        afull_d  = (count_d >= CW'(AF_LEVEL));
        aempty_d = (count_d <= CW'(AE_LEVEL));
        ovf_d    = bus.winc & wfull_q;
        unf_d    = bus.rinc & rempty_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            wfull_q  <= 1'b0;
            rempty_q <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            wfull_q  <= wfull_d;
            rempty_q <= rempty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_acc_c) begin
            mem_q[wptr_q] <= bus.wdata;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.rdata  = mem_q[rptr_q];
            assign bus.rvalid = ~rempty_q;
        end else begin : g_std
            assign bus.rdata  = rdata_q;
            assign bus.rvalid = rvalid_q;
        end
    endgenerate

    assign bus.wfull        = wfull_q;
    assign bus.rempty       = rempty_q;
    assign bus.almost_full  = afull_q;
    assign bus.almost_empty = aempty_q;
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: a standard-read instance checked through a read-data
// scoreboard plus direct flag checks, and a first-word-fall-through instance.
module tb_sync_fifo_flags;
    logic clk;
    logic rstn;
    int   vectors;
    int   miscompares;
    logic [7:0] exp_q [$];

    sync_fifo_flags_if #(.WIDTH(8), .DEPTH(16)) if0 ();
    sync_fifo_flags_if #(.WIDTH(8), .DEPTH(16)) if1 ();

    sync_fifo_flags #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(3), .FWFT(0)) dut0 (
        .clk(clk), .rstn(rstn), .bus(if0.slave));
    sync_fifo_flags #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(3), .FWFT(1)) dut1 (
        .clk(clk), .rstn(rstn), .bus(if1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step0(input logic w, input logic [7:0] d, input logic r);
        if0.winc = w; if0.wdata = d; if0.rinc = r;
        @(posedge clk); #1;
        if0.winc = 1'b0; if0.rinc = 1'b0;
    endtask

    task automatic step1(input logic w, input logic [7:0] d, input logic r);
        if1.winc = w; if1.wdata = d; if1.rinc = r;
        @(posedge clk); #1;
        if1.winc = 1'b0; if1.rinc = 1'b0;
    endtask

    task automatic chk_reset0(input string tag);
        chk({tag, "_rempty"}, 32'(if0.rempty), 1);
        chk({tag, "_wfull"}, 32'(if0.wfull), 0);
        chk({tag, "_count"}, 32'(if0.count), 0);
        chk({tag, "_aempty"}, 32'(if0.almost_empty), 1);
        chk({tag, "_afull"}, 32'(if0.almost_full), 0);
        chk({tag, "_rvalid"}, 32'(if0.rvalid), 0);
        chk({tag, "_rdata"}, 32'(if0.rdata), 0);
        chk({tag, "_ovf"}, 32'(if0.overflow), 0);
        chk({tag, "_unf"}, 32'(if0.underflow), 0);
    endtask

    // Read-data monitor: every rvalid on the standard instance consumes one expected word
    initial begin
        forever begin
            @(negedge clk);
            if (rstn && if0.rvalid) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rdata_unexpected: got %0h with rvalid, expected no read", if0.rdata);
                end else begin
                    chk("rdata", 32'(if0.rdata), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors = 0; miscompares = 0;
        if0.winc = 1'b0; if0.wdata = '0; if0.rinc = 1'b0;
        if1.winc = 1'b0; if1.wdata = '0; if1.rinc = 1'b0;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset0("reset");
        rstn = 1'b1;
        step0(1'b0, 8'h00, 1'b0);

        // Fill to full, checking thresholds on every step
        for (int i = 0; i < 16; i++) begin
            step0(1'b1, 8'(i), 1'b0);
            chk("fill_count", 32'(if0.count), 32'(i + 1));
            chk("fill_afull", 32'(if0.almost_full), (i + 1 >= 12) ? 1 : 0);
            chk("fill_aempty", 32'(if0.almost_empty), (i + 1 <= 3) ? 1 : 0);
        end
        chk("full_wfull", 32'(if0.wfull), 1);
        step0(1'b1, 8'hEE, 1'b0);
        chk("ovf_pulse", 32'(if0.overflow), 1);
        chk("ovf_count", 32'(if0.count), 16);
        step0(1'b0, 8'h00, 1'b0);
        chk("ovf_clear", 32'(if0.overflow), 0);

        // Drain in order, then one extra read
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'(i));
            step0(1'b0, 8'h00, 1'b1);
        end
        chk("drain_rempty", 32'(if0.rempty), 1);
        step0(1'b0, 8'h00, 1'b1);
        chk("unf_pulse", 32'(if0.underflow), 1);
        chk("unf_rvalid", 32'(if0.rvalid), 0);
        chk("unf_rdata_hold", 32'(if0.rdata), 32'h0F);
        step0(1'b0, 8'h00, 1'b0);
        chk("unf_clear", 32'(if0.underflow), 0);

        // Steady occupancy of 5 with simultaneous write/read across pointer wrap
        for (int i = 0; i < 5; i++) step0(1'b1, 8'(8'h20 + i), 1'b0);
        for (int i = 0; i < 40; i++) begin
            exp_q.push_back(8'(8'h20 + i));
            step0(1'b1, 8'(8'h25 + i), 1'b1);
            chk("steady_count", 32'(if0.count), 5);
        end
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(8'(8'h48 + i));
            step0(1'b0, 8'h00, 1'b1);
        end
        chk("steady_empty", 32'(if0.rempty), 1);

        // Full with write+read: read wins; empty with write+read: write wins
        for (int i = 0; i < 16; i++) step0(1'b1, 8'(8'h50 + i), 1'b0);
        exp_q.push_back(8'h50);
        step0(1'b1, 8'hEE, 1'b1);
        chk("fullrw_count", 32'(if0.count), 15);
        chk("fullrw_ovf", 32'(if0.overflow), 1);
        chk("fullrw_wfull", 32'(if0.wfull), 0);
        for (int i = 0; i < 15; i++) begin
            exp_q.push_back(8'(8'h51 + i));
            step0(1'b0, 8'h00, 1'b1);
        end
        chk("emptyrw_pre", 32'(if0.rempty), 1);
        step0(1'b1, 8'h77, 1'b1);
        chk("emptyrw_count", 32'(if0.count), 1);
        chk("emptyrw_unf", 32'(if0.underflow), 1);
        exp_q.push_back(8'h77);
        step0(1'b0, 8'h00, 1'b1);
        step0(1'b0, 8'h00, 1'b0);
        chk("emptyrw_done", 32'(if0.count), 0);

        // First-word-fall-through instance
        step1(1'b1, 8'hA5, 1'b0);
        chk("fwft_rdata", 32'(if1.rdata), 32'hA5);
        chk("fwft_rvalid", 32'(if1.rvalid), 1);
        chk("fwft_rempty", 32'(if1.rempty), 0);
        step1(1'b0, 8'h00, 1'b1);
        chk("fwft_pop_rempty", 32'(if1.rempty), 1);
        chk("fwft_pop_rvalid", 32'(if1.rvalid), 0);
        for (int i = 0; i < 7; i++) step1(1'b1, 8'(8'hC0 + i), 1'b0);
        chk("fwft_count7", 32'(if1.count), 7);
        chk("fwft_head", 32'(if1.rdata), 32'hC0);

        // Asynchronous reset mid-cycle
        #3;
        rstn = 1'b0;
        #1;
        chk("async_count", 32'(if1.count), 0);
        chk("async_rempty", 32'(if1.rempty), 1);
        chk("async_wfull", 32'(if1.wfull), 0);
        chk("async_aempty", 32'(if1.almost_empty), 1);
        chk("async_afull", 32'(if1.almost_full), 0);
        chk("async_rvalid", 32'(if1.rvalid), 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        step1(1'b1, 8'h99, 1'b0);
        chk("postrst_rdata", 32'(if1.rdata), 32'h99);
        chk("postrst_count", 32'(if1.count), 1);

        step0(1'b0, 8'h00, 1'b0);
        step0(1'b0, 8'h00, 1'b0);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
